// File: rtl/dff4_ce_rr_ctrl.sv
// Round-robin write controller for a shared clock-enabled register.
// Grants one requester (or a clear) per 3-cycle transaction.
module dff4_ce_rr_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_clr_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_din,
  input  logic                  i_clr_req,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_ce,
  output logic [WIDTH-1:0]      o_d,
  output logic                  o_clr,
  output logic                  o_ack,
  output logic [IDW-1:0]        o_owner,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_win;
  logic [NREQ-1:0] r_gnt;
  logic            r_ce;
  logic            r_clr;
  logic            r_ack;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_nptr;
  logic [NREQ-1:0] w_onehot;

  // First set request at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_onehot = NREQ'(1) << w_win;
  assign w_nptr   = IDW'((int'(r_win) + 1) % NREQ);

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_ce    <= 1'b0;
      r_clr   <= 1'b1;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (i_clr_req) begin
            r_state <= S_CLEAR;
            r_clr   <= 1'b1;
            r_gnt   <= '0;
          end else if (w_found) begin
            r_state <= S_WRITE;
            r_clr   <= 1'b0;
            r_ce    <= 1'b1;
            r_gnt   <= w_onehot;
            r_win   <= w_win;
          end else begin
            r_clr   <= 1'b0;
          end
        end
        S_WRITE: begin
          r_state <= S_ACK;
          r_ce    <= 1'b0;
          r_ack   <= 1'b1;
          r_owner <= r_win;
          r_ptr   <= w_nptr;
        end
        S_CLEAR: begin
          r_state <= S_ACK;
          r_clr   <= 1'b0;
          r_ack   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_gnt   <= '0;
          r_ce    <= 1'b0;
          r_clr   <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt   = r_gnt;
  assign o_ce    = r_ce;
  assign o_d     = r_ce ? i_din[int'(r_win)*WIDTH +: WIDTH] : '0;
  assign o_clr   = r_clr;
  assign o_ack   = r_ack;
  assign o_owner = r_owner;
  assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dff4_ce_rr_ctrl.sv
// Directed bench for dff4_ce_rr_ctrl with a behavioural dff4_ce model.
// Each step advances one clock and checks outputs 1 ns after the edge.
module tb_dff4_ce_rr_ctrl;

  logic        clk;
  logic        clr_n;
  logic [3:0]  req;
  logic [15:0] din;
  logic        clr_req;
  logic [3:0]  gnt;
  logic        ce;
  logic [3:0]  d;
  logic        clr;
  logic        ack;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  q;

  int checks;
  int failures;

  dff4_ce_rr_ctrl #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
    .i_clk     (clk),
    .i_clr_n   (clr_n),
    .i_req     (req),
    .i_din     (din),
    .i_clr_req (clr_req),
    .o_gnt     (gnt),
    .o_ce      (ce),
    .o_d       (d),
    .o_clr     (clr),
    .o_ack     (ack),
    .o_owner   (owner),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared register the controller drives.
  always_ff @(posedge clk) begin
    if (clr)     q <= 4'h0;
    else if (ce) q <= d;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ce_clr_excl", {31'd0, ce & clr}, 32'd0);
    chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
  endtask

  logic [3:0] exp_g;

  initial begin
    checks   = 0;
    failures = 0;
    clr_n    = 1'b0;
    req      = 4'b1111;
    din      = 16'h0;
    clr_req  = 1'b0;

    // Reset held 2 cycles with all requests high
    tick();
    tick();
    chk("rst_clr", {31'd0, clr}, 32'd1);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_ce", {31'd0, ce}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_d", {28'd0, d}, 32'd0);
    chk("rst_q", {28'd0, q}, 32'd0);
    clr_n = 1'b1;
    req   = 4'b0000;
    tick();
    chk("rel_clr", {31'd0, clr}, 32'd0);
    chk("rel_busy", {31'd0, busy}, 32'd0);

    // Round robin from ptr=0: 0,1,2,3,0
    din = 16'h4321;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      tick();
      chk("rr_gnt", {28'd0, gnt}, {28'd0, exp_g});
      chk("rr_ce", {31'd0, ce}, 32'd1);
      chk("rr_d", {28'd0, d}, (i % 4) + 1);
      chk("rr_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("rr_ack", {31'd0, ack}, 32'd1);
      chk("rr_q", {28'd0, q}, (i % 4) + 1);
      chk("rr_owner", {30'd0, owner}, i % 4);
      chk("rr_ack_gnt", {28'd0, gnt}, {28'd0, exp_g});
      chk("rr_ack_d", {28'd0, d}, 32'd0);
      if (i == 4) req = 4'b0000;
      tick();
      chk("rr_idle_ack", {31'd0, ack}, 32'd0);
      chk("rr_idle_gnt", {28'd0, gnt}, 32'd0);
    end

    // Single write, ptr=1 now
    din = 16'h0A00;
    req = 4'b0100;
    tick();
    chk("sw_gnt", {28'd0, gnt}, 32'b0100);
    chk("sw_ce", {31'd0, ce}, 32'd1);
    chk("sw_d", {28'd0, d}, 32'hA);
    tick();
    chk("sw_ack", {31'd0, ack}, 32'd1);
    chk("sw_q", {28'd0, q}, 32'hA);
    chk("sw_owner", {30'd0, owner}, 32'd2);
    req = 4'b0000;
    tick();
    chk("sw_idle", {31'd0, busy}, 32'd0);

    // Load 5 via requester 0 (ptr=3 wraps to 0)
    din = 16'h0005;
    req = 4'b0001;
    tick();
    chk("ld5_gnt", {28'd0, gnt}, 32'b0001);
    tick();
    chk("ld5_q", {28'd0, q}, 32'h5);
    req = 4'b0000;
    tick();

    // Clear priority over req[0]
    clr_req = 1'b1;
    req     = 4'b0001;
    tick();
    chk("cp_clr", {31'd0, clr}, 32'd1);
    chk("cp_ce", {31'd0, ce}, 32'd0);
    chk("cp_gnt", {28'd0, gnt}, 32'd0);
    chk("cp_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("cp_ack", {31'd0, ack}, 32'd1);
    chk("cp_q", {28'd0, q}, 32'h0);
    chk("cp_clr_ack", {31'd0, clr}, 32'd0);
    chk("cp_gnt_ack", {28'd0, gnt}, 32'd0);
    chk("cp_owner", {30'd0, owner}, 32'd0);
    clr_req = 1'b0;
    tick();
    chk("cp_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("cp_next_gnt", {28'd0, gnt}, 32'b0001);
    chk("cp_next_d", {28'd0, d}, 32'h5);
    tick();
    chk("cp_next_q", {28'd0, q}, 32'h5);
    req = 4'b0000;
    tick();

    // Mid-operation reset during WRITE of requester 3 (ptr=1)
    din = 16'h7005;
    req = 4'b1000;
    tick();
    chk("mr_gnt", {28'd0, gnt}, 32'b1000);
    clr_n = 1'b0;
    tick();
    chk("mr_ack", {31'd0, ack}, 32'd0);
    chk("mr_owner", {30'd0, owner}, 32'd0);
    chk("mr_clr", {31'd0, clr}, 32'd1);
    chk("mr_gnt0", {28'd0, gnt}, 32'd0);
    chk("mr_q_loaded", {28'd0, q}, 32'h7);
    clr_n = 1'b1;
    req   = 4'b1001;
    tick();
    chk("mr_q_cleared", {28'd0, q}, 32'h0);
    chk("mr_ptr0_gnt", {28'd0, gnt}, 32'b0001);
    chk("mr_clr_rel", {31'd0, clr}, 32'd0);
    tick();
    chk("mr_ack2", {31'd0, ack}, 32'd1);
    chk("mr_q2", {28'd0, q}, 32'h5);
    req = 4'b0000;
    tick();

    // 1-cycle req[1] pulse during ACK is ignored (ptr=1)
    req = 4'b0001;
    tick();
    chk("ip_gnt", {28'd0, gnt}, 32'b0001);
    tick();
    chk("ip_ack", {31'd0, ack}, 32'd1);
    req = 4'b0010;
    tick();
    chk("ip_idle", {31'd0, busy}, 32'd0);
    req = 4'b0000;
    tick();
    chk("ip_stay_busy", {31'd0, busy}, 32'd0);
    chk("ip_stay_gnt", {28'd0, gnt}, 32'd0);
    tick();
    chk("ip_stay_ce", {31'd0, ce}, 32'd0);
    chk("ip_owner", {30'd0, owner}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff4_ce_rr_ctrl.md
# dff4_ce_rr_ctrl

Round-robin write controller for the shared 4-bit clock-enabled register (`dff4_ce`). It arbitrates between NREQ requesters and a clear requester, and drives the register's `ce`, `d` and `clr` inputs so that exactly one update happens per granted transaction. It returns a one-cycle `ack` to the winner once the new value is on the register's `q`. It sits between the requesting datapath blocks and the single `dff4_ce` instance they share.

## Interface
- `NREQ`, 4, number of data requesters (2..8).
- `WIDTH`, 4, data width; must match the register width.
- `IDW`, 2, width of the owner index; must be at least clog2(NREQ).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr_n`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  per-requester write request; level, held until `ack`.
- `din`  in  NREQ*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH].
- `clr_req`  in  1  request to clear the shared register; level, held until `ack`.
- `gnt`  out  NREQ  one-hot grant, registered.
- `ce`  out  1  clock enable to the register.
- `d`  out  WIDTH  data to the register.
- `clr`  out  1  clear to the register; registered, glitch-free.
- `ack`  out  1  one-cycle completion pulse to the current winner.
- `owner`  out  IDW  index of the last data requester written.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WRITE, CLEAR, ACK.
- **IDLE**
  - `clr_req`=1 -> CLEAR. `clr_req` has priority over all `req` bits.
  - Otherwise any `req` bit set -> WRITE. The winner is the first set bit at or after `ptr`, searching upward modulo NREQ.
  - Otherwise stay in IDLE.
- **WRITE** (1 cycle)
  - `gnt` = one-hot of the winner; `ce`=1; `d` = winner's `din` slice.
  - `din` is sampled combinationally in this cycle and must be stable.
  - Next state ACK.
- **CLEAR** (1 cycle)
  - `clr`=1, `ce`=0, `gnt`=0.
  - Next state ACK.
- **ACK** (1 cycle)
  - `ack`=1; `gnt` holds its WRITE value (0 after CLEAR); `ce`=0; `clr`=0.
  - After a write: `owner` <= winner, `ptr` <= (winner+1) mod NREQ.
  - After a clear: `ptr` and `owner` unchanged.
  - Next state IDLE.
- Requesters must drop `req`/`clr_req` in the cycle after `ack`. A request still high in IDLE is treated as a new request.
- Request bits are sampled only in IDLE. A request that rises and falls while `busy`=1 is ignored.
- `d` = 0 whenever `ce`=0.
- Reset values:
  - state IDLE, `ptr`=0, `owner`=0, `gnt`=0, `ce`=0, `ack`=0, `busy`=0, `d`=0.
  - `clr`=1, so the register is cleared while `clr_n` is low. `clr` falls in the first cycle after `clr_n` goes high.
- Reset asserted mid-transaction aborts it: no `ack`, `ptr`/`owner` return to 0.
- A write whose WRITE cycle has already completed stays in the register until the reset-driven `clr` clears it.

## Timing
- Request latency: a request seen in IDLE at edge N gives `gnt`/`ce` high in cycle N+1.
- The register loads at the edge ending N+1; `q` holds the new value during ACK (N+2), coincident with `ack`=1.
- Clear path: `clr`=1 in cycle N+1; `q`=0 by ACK (N+2).
- Minimum transaction is 3 cycles (IDLE, WRITE/CLEAR, ACK), so back-to-back throughput is one update per 3 cycles.
- Fairness: with all NREQ requesters continuously active, each is granted once every 3*NREQ cycles.
- `ce` and `clr` are never high in the same cycle.
- At most one `gnt` bit is set at any time.

## Test plan
- Reset: hold `clr_n`=0 for 2 cycles with `req`=4'b1111 -> `clr`=1, `gnt`=0, `ce`=0, `ack`=0, `busy`=0; `clr`=0 one cycle after release.
- Single write: `req`=4'b0100, `din[11:8]`=4'hA -> WRITE: `gnt`=4'b0100, `ce`=1, `d`=4'hA; next cycle `ack`=1, `q`=4'hA, `owner`=2.
- Round-robin: `req`=4'b1111 held with `din` slices 1,2,3,4 -> grants in order 0,1,2,3,0; `q` sequence 1,2,3,4,1; `ack` every 3rd cycle.
- Clear priority: `clr_req`=1 together with `req`=4'b0001, `q`=4'h5 -> CLEAR first (`clr`=1, `ce`=0), `q`=0 at `ack`; requester 0 granted on the next transaction.
- Mid-operation reset: `clr_n`=0 during the WRITE of requester 3 -> no `ack`; `owner`=0, `ptr`=0, `clr`=1; the next `req`=4'b1001 is granted to requester 0.
- Ignored pulse: a 1-cycle `req[1]` pulse during ACK -> no grant to 1, FSM returns to IDLE and stays there.
